// File: rtl/bank_pkg.sv
// ---------------------------------------------------------------------------
// bank_pkg
// Shared constants and types for the bank-to-crossbar return path.
//   CH_NUM_DEF    : default number of crossbar channels
//   ROB_DEPTH_DEF : default reorder-buffer entries per channel
//   ROB_NUM_W     : width of a ROB slot number
//   CH_ID_W       : width of a channel id
//   XBAR_DATA_W   : return data width
//   xbar_tag_t    : {channel_id, rob_num} tag carried by every return beat
// ---------------------------------------------------------------------------
package bank_pkg;

    localparam int CH_NUM_DEF    = 4;
    localparam int ROB_DEPTH_DEF = 8;
    localparam int ROB_NUM_W     = 3;
    localparam int CH_ID_W       = 2;
    localparam int XBAR_DATA_W   = 128;

    typedef struct packed {
        logic [CH_ID_W-1:0]   channel_id;
        logic [ROB_NUM_W-1:0] rob_num;
    } xbar_tag_t;

endpackage

// File: rtl/bank_xbar_rob_ch.sv
// ---------------------------------------------------------------------------
// bank_xbar_rob_ch
// Single-channel reorder buffer. Slots are handed out in order at the tail,
// filled in any order by tagged returns, and drained strictly in order from
// the head.
// Optional build macro: BANK_XBAR_ROB_CHECK_EN enables detection of fills to
// unallocated or already-valid slots (sticky err_o).
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   alloc_fire_i       : allocation accepted this cycle (already qualified)
//   alloc_ready_o      : channel not full
//   alloc_rob_num_o    : slot number at the tail
//   fill_fire_i        : return beat for this channel
//   fill_rob_num_i     : slot of the return beat
//   fill_data_i        : return data
//   rtn_valid_o        : head slot holds valid data
//   rtn_ready_i        : consumer accepts head data
//   rtn_data_o         : head slot data
//   err_o              : sticky protocol error
// ---------------------------------------------------------------------------
module bank_xbar_rob_ch
    import bank_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int DATA_W    = XBAR_DATA_W,
    parameter int ROB_W     = $clog2(ROB_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              alloc_fire_i,
    output logic              alloc_ready_o,
    output logic [ROB_W-1:0]  alloc_rob_num_o,
    input  logic              fill_fire_i,
    input  logic [ROB_W-1:0]  fill_rob_num_i,
    input  logic [DATA_W-1:0] fill_data_i,
    output logic              rtn_valid_o,
    input  logic              rtn_ready_i,
    output logic [DATA_W-1:0] rtn_data_o,
    output logic              err_o
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ROB_W:0]          head_q, head_d;
    logic [ROB_W:0]          tail_q, tail_d;
    logic [ROB_W:0]          count;
    logic [ROB_DEPTH-1:0]    valid_q, valid_d;
    logic [DATA_W-1:0]       data_q [ROB_DEPTH];
    logic [ROB_W-1:0]        head_idx;
    logic                    drain_fire;

    assign head_idx        = head_q[ROB_W-1:0];
    assign count           = tail_q - head_q;
    assign alloc_ready_o   = (count != (ROB_W+1)'(ROB_DEPTH));
    assign alloc_rob_num_o = tail_q[ROB_W-1:0];
    assign rtn_valid_o     = valid_q[head_idx];
    assign rtn_data_o      = data_q[head_idx];
    assign drain_fire      = rtn_valid_o && rtn_ready_i;

    always_comb begin
        head_d  = head_q + {{ROB_W{1'b0}}, drain_fire};
        tail_d  = tail_q + {{ROB_W{1'b0}}, alloc_fire_i};
        valid_d = valid_q;
        if (drain_fire) begin
            valid_d[head_idx] = 1'b0;
        end
        // A legal fill never targets the slot being drained (it is already
        // valid), so the set can safely follow the clear.
        if (fill_fire_i) begin
            valid_d[fill_rob_num_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
        end
    end

    // Data storage is intentionally not reset; valid bits gate its use.
    always_ff @(posedge clk_i) begin
        if (fill_fire_i) begin
            data_q[fill_rob_num_i] <= fill_data_i;
        end
    end

`ifdef BANK_XBAR_ROB_CHECK_EN
    logic [ROB_W-1:0] fill_off;
    logic             fill_allocated;
    logic             fill_bad;
    logic             err_q, err_d;

    // Slot is allocated when its distance from head (mod depth) is below the
    // current occupancy; this handles pointer wrap without extra compares.
    assign fill_off       = fill_rob_num_i - head_idx;
    assign fill_allocated = ({1'b0, fill_off} < count);
    assign fill_bad       = fill_fire_i && (!fill_allocated || valid_q[fill_rob_num_i]);
    assign err_d          = err_q || fill_bad;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: rtl/bank_xbar_rob.sv
// ---------------------------------------------------------------------------
// bank_xbar_rob
// Receiving end of the bank-to-crossbar return interface. Grants per-channel
// ROB numbers at issue, accepts out-of-order tagged returns and drains each
// channel in allocation order. Never backpressures the SRAM controller.
// Optional build macro: BANK_XBAR_ROB_CHECK_EN (fill protocol checking).
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   alloc_valid_i/ready_o  : ROB slot request handshake
//   alloc_ch_id_i          : channel for the allocation
//   alloc_rob_num_o        : granted slot (combinational from tail)
//   sc_xbar_valid_i/ready_o: return beat handshake (ready tied high)
//   sc_xbar_channel_id_i   : return channel
//   sc_xbar_rob_num_i      : return slot
//   sc_xbar_data_i         : return data
//   ch_rtn_valid_o/ready_i : per-channel in-order drain handshake
//   ch_rtn_data_o          : per-channel data, channel c at [c*DATA_W +: DATA_W]
//   err_o                  : sticky protocol error (OR of all channels)
// ---------------------------------------------------------------------------
module bank_xbar_rob
    import bank_pkg::*;
#(
    parameter int CH_NUM    = CH_NUM_DEF,
    parameter int ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int DATA_W    = XBAR_DATA_W,
    parameter int CH_W      = $clog2(CH_NUM),
    parameter int ROB_W     = $clog2(ROB_DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     alloc_valid_i,
    output logic                     alloc_ready_o,
    input  logic [CH_W-1:0]          alloc_ch_id_i,
    output logic [ROB_W-1:0]         alloc_rob_num_o,
    input  logic                     sc_xbar_valid_i,
    output logic                     sc_xbar_ready_o,
    input  logic [CH_W-1:0]          sc_xbar_channel_id_i,
    input  logic [ROB_W-1:0]         sc_xbar_rob_num_i,
    input  logic [DATA_W-1:0]        sc_xbar_data_i,
    output logic [CH_NUM-1:0]        ch_rtn_valid_o,
    input  logic [CH_NUM-1:0]        ch_rtn_ready_i,
    output logic [CH_NUM*DATA_W-1:0] ch_rtn_data_o,
    output logic                     err_o
);

    xbar_tag_t          fill_tag;
    logic [CH_NUM-1:0]  ch_alloc_ready;
    logic [CH_NUM-1:0]  ch_alloc_fire;
    logic [CH_NUM-1:0]  ch_fill_fire;
    logic [CH_NUM-1:0]  ch_err;
    logic [ROB_W-1:0]   ch_rob_num [CH_NUM];

    assign fill_tag        = xbar_tag_t'({sc_xbar_channel_id_i, sc_xbar_rob_num_i});
    assign sc_xbar_ready_o = 1'b1;
    assign alloc_ready_o   = ch_alloc_ready[alloc_ch_id_i];
    assign alloc_rob_num_o = ch_rob_num[alloc_ch_id_i];
    assign err_o           = |ch_err;

    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
            assign ch_alloc_fire[gi] = alloc_valid_i && ch_alloc_ready[gi] &&
                                       (alloc_ch_id_i == CH_W'(gi));
            assign ch_fill_fire[gi]  = sc_xbar_valid_i && (fill_tag.channel_id == CH_W'(gi));

            bank_xbar_rob_ch #(
                .ROB_DEPTH (ROB_DEPTH),
                .DATA_W    (DATA_W),
                .ROB_W     (ROB_W)
            ) u_ch (
                .clk_i           (clk_i),
                .rst_ni          (rst_ni),
                .alloc_fire_i    (ch_alloc_fire[gi]),
                .alloc_ready_o   (ch_alloc_ready[gi]),
                .alloc_rob_num_o (ch_rob_num[gi]),
                .fill_fire_i     (ch_fill_fire[gi]),
                .fill_rob_num_i  (fill_tag.rob_num),
                .fill_data_i     (sc_xbar_data_i),
                .rtn_valid_o     (ch_rtn_valid_o[gi]),
                .rtn_ready_i     (ch_rtn_ready_i[gi]),
                .rtn_data_o      (ch_rtn_data_o[gi*DATA_W +: DATA_W]),
                .err_o           (ch_err[gi])
            );
        end
    endgenerate

endmodule

// File: doc/bank_xbar_rob.md
Name: bank_xbar_rob

Overview:
- Receiving end of the bank-to-crossbar return interface (sc_xbar_*) driven by the bank SRAM controller.
- Replaces the fake crossbar ready model.
- Hands out per-channel ROB numbers to requesters at issue time, accepts out-of-order data returns tagged {channel_id, rob_num}, and drains each channel strictly in allocation order.

Parameters:
- CH_NUM, 4, number of crossbar channels.
- ROB_DEPTH, 8, entries per channel; must be a power of 2, and log2 equals the rob_num width (3).
- DATA_W, 128, return data width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- alloc_valid_i  in  1  requester asks for a ROB slot.
- alloc_ready_o  out  1  slot available in the addressed channel.
- alloc_ch_id_i  in  2  channel of the allocation.
- alloc_rob_num_o  out  3  ROB number granted; valid while alloc_valid_i is high.
- sc_xbar_valid_i  in  1  return beat valid.
- sc_xbar_ready_o  out  1  return beat accepted.
- sc_xbar_channel_id_i  in  2  return channel.
- sc_xbar_rob_num_i  in  3  return ROB slot.
- sc_xbar_data_i  in  DATA_W  return data.
- ch_rtn_valid_o  out  CH_NUM  per-channel in-order data valid.
- ch_rtn_ready_i  in  CH_NUM  per-channel consumer ready.
- ch_rtn_data_o  out  CH_NUM*DATA_W  per-channel data; channel c occupies bits [c*DATA_W +: DATA_W].
- err_o  out  1  sticky protocol error.

Behaviour:
Per-channel state:
- head and tail pointers, each 4 bits (3 index bits plus 1 wrap bit).
- valid[7:0] vector.
- data array of 8 x DATA_W.
- count = tail - head, modulo 16.
- Full when count == 8; empty when count == 0.

Reset (rst_ni low, asynchronous):
- head = tail = 0; all valid bits cleared; err_o = 0.
- All outputs are 0 except sc_xbar_ready_o = 1.
- Data array is not reset.

Allocation:
- alloc_ready_o = !full[alloc_ch_id_i].
- alloc_rob_num_o = tail[alloc_ch_id_i][2:0], combinational.
- Fire (valid & ready): tail[ch] increments by 1. It wraps 7 -> 0 and toggles the wrap bit.
- One allocation per cycle.

Fill:
- sc_xbar_ready_o is constantly 1; the block never backpressures the SRAM controller.
- Fire: data[ch][rob] <= sc_xbar_data_i and valid[ch][rob] <= 1.
- Data is visible on the drain side the next cycle, so fill-to-output latency is 1 cycle.

Drain, per channel, independently:
- ch_rtn_valid_o[c] = valid[c][head[c][2:0]].
- ch_rtn_data_o slice c = data[c][head[c][2:0]].
- Fire: clear the valid bit at head; head increments by 1 with wrap.
- All channels may drain in the same cycle.

Simultaneous events:
- Alloc and drain on the same channel in one cycle: both take effect. alloc_ready_o uses the pre-update count, with no same-cycle bypass, so a full channel draining this cycle still shows alloc_ready_o = 0.
- Fill and drain on the same channel, different slots, in one cycle: both take effect.
- Fill into the head slot of an empty-valid head: valid is seen next cycle, with no bypass.
- A slot being drained cannot be filled in the same cycle, since it already holds a valid.

Error handling:
- Out-of-range or duplicate fills corrupt nothing beyond their own slot.
- Detection is defined only under the Optional Feature.

Reset mid-operation:
- Pending data is discarded and all pointers return to 0.
- Outstanding returns arriving after reset are the system's responsibility.

Optional Feature:
- Macro BANK_XBAR_ROB_CHECK_EN.
- When defined, a fill sets err_o (sticky until reset) in either of these cases:
  - The slot is not currently allocated: index not in [head, tail) with wrap-aware compare.
  - valid is already set for that slot.
- A flagged fill still writes the data, to keep the datapath identical.
- When not defined, err_o is tied to 0 and no check logic is built.

Decomposition:
- Shared package bank_pkg holds:
  - constants CH_NUM_DEF = 4, ROB_DEPTH_DEF = 8, ROB_NUM_W = 3, XBAR_DATA_W = 128;
  - a typedef for the {channel_id, rob_num} tag.
- One sub-module, bank_xbar_rob_ch: a single-channel ROB holding pointers, valid bits, data array, the drain port and the error check.
- Top level instantiates CH_NUM copies and decodes the channel id for the alloc and fill strobes.

Test Plan:
- In-order return: allocate ch0 rob 0,1,2; return 0,1,2 with data 0xA0..0xA2; ch_rtn_ready_i = 4'b0001 -> ch0 outputs 0xA0, 0xA1, 0xA2 on consecutive cycles, first valid 1 cycle after the first fill.
- Reorder: allocate ch1 rob 0..3; return order 3,1,0,2 -> ch1 valid rises only after rob 0 fills; output order follows rob 0,1,2,3.
- Full/wrap: allocate 8 on ch2 -> alloc_ready_o = 0 for ch2 while ch3 stays ready. Fill and drain 2 entries, then allocate 2 more -> granted rob numbers 0 and 1 (wrap); count returns to 8.
- Backpressure and parallel drain: fill all channels and hold ch_rtn_ready_i = 0 for 5 cycles -> outputs stable, data unchanged. Set ready = 4'b1111 -> all 4 channels drain in the same cycle.
- Simultaneous alloc+drain at full on ch0 -> alloc refused that cycle and accepted the next cycle.
- With BANK_XBAR_ROB_CHECK_EN: fill ch0 rob 5 with head = tail = 0 -> err_o = 1 next cycle and held until rst_ni is asserted. Without the macro: err_o stays 0.
